// File: rtl/mont_mul_rk_pkg.sv
// Shared encodings for the Montgomery multiplier: FSM states, op codes, operand selects.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`ifndef DATA_WORD
`define DATA_WORD 2'd2
`endif

package mont_mul_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH_B = 3'd1,
        ST_FETCH_N = 3'd2,
        ST_FETCH_A = 3'd3,
        ST_RUN     = 3'd4,
        ST_CLEANUP = 3'd5,
        ST_WRITE   = 3'd6
    } state_t;

    localparam logic MM_OP_MUL = 1'b0;
    localparam logic MM_OP_SQR = 1'b1;

    localparam logic [1:0] SEL_B   = 2'd0;
    localparam logic [1:0] SEL_N   = 2'd1;
    localparam logic [1:0] SEL_A   = 2'd2;
    localparam logic [1:0] SEL_RES = 2'd3;

endpackage

// File: rtl/mont_mul_rk_if.sv
// LSU request/response bundle between the multiplier (master) and the core LSU (slave).
// Latency: n/a (wires only).
// Backpressure: master holds a request stable until the slave pulses lsu_done.
interface mont_mul_rk_if;
    logic        lsu_ren;
    logic        lsu_wen;
    logic [1:0]  lsu_type;
    logic [31:0] lsu_addr_offset;
    logic [1:0]  op_address_sel;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic [31:0] lsu_wdata;

    modport master (
        output lsu_ren, lsu_wen, lsu_type, lsu_addr_offset, op_address_sel, lsu_wdata,
        input  lsu_done, lsu_rdata
    );

    modport slave (
        input  lsu_ren, lsu_wen, lsu_type, lsu_addr_offset, op_address_sel, lsu_wdata,
        output lsu_done, lsu_rdata
    );
endinterface

// File: rtl/mont_mul_rk_step.sv
// One radix-2 Montgomery step: M' = (M + a*B + q*N) / 2 with q chosen to make the sum even.
// Latency: combinational.
// Backpressure: none.
module mont_step #(
    parameter int BITS = 128
) (
    input  logic [BITS+1:0] m_in,
    input  logic [BITS-1:0] b,
    input  logic [BITS-1:0] n,
    input  logic            a_bit,
    output logic [BITS+1:0] m_out
);
    logic [BITS+1:0] sum_ab;
    logic [BITS+1:0] sum_abn;

    // add B when the A bit is set, then N when odd, then halve
    always_comb begin
        sum_ab  = m_in + (a_bit ? {2'b00, b} : '0);
        sum_abn = sum_ab[0] ? (sum_ab + {2'b00, n}) : sum_ab;
        m_out   = {1'b0, sum_abn[BITS+1:1]};
    end
endmodule

// File: rtl/mont_mul_rk.sv
// Montgomery multiplier A*B*2^-BITS mod N (or B*B), operands fetched/written through the LSU.
// Latency: 1 + 2*WORDS + WORDS*(1 + 32/RADIX_BITS) + 1 + WORDS cycles with a zero-wait LSU (MUL).
// Backpressure: each LSU request is held stable until lsu_done; MONT_MUL_N_CACHE_EN enables N reuse.
module mont_mul_rk
    import mont_mul_pkg::*;
#(
    parameter int WORDS      = 4,
    parameter int RADIX_BITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  op,
    input  logic                  keep_n,
    mont_mul_rk_if.master         lsu,
    output logic [32*WORDS-1:0]   result,
    output logic                  busy,
    output logic                  done
);
    localparam int BITS = 32 * WORDS;
    localparam int CW   = $clog2(WORDS);
    localparam int BW   = $clog2(BITS) + 1;

    state_t            state_q, state_d;
    logic [BITS+1:0]   m_q, m_d;
    logic [BITS-1:0]   b_q, b_d;
    logic [BITS-1:0]   n_q, n_d;
    logic [31:0]       a_sh_q, a_sh_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              op_q, op_d;
    logic              ren_q, ren_d;
    logic              wen_q, wen_d;
    logic [1:0]        sel_q, sel_d;
    logic [31:0]       off_q, off_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              skip_n;
    logic [BITS+1:0]   chain [RADIX_BITS+1];

    // RADIX_BITS chained steps, LSB of the A shift register first
    assign chain[0] = m_q;
    for (genvar g = 0; g < RADIX_BITS; g++) begin : g_step
        mont_step #(.BITS(BITS)) u_step (
            .m_in  (chain[g]),
            .b     (b_q),
            .n     (n_q),
            .a_bit (a_sh_q[g]),
            .m_out (chain[g+1])
        );
    end

`ifdef MONT_MUL_N_CACHE_EN
    logic n_valid_q, n_valid_d;
    logic skip_n_q, skip_n_d;

    // N cache: valid after a completed N fetch; skip decision frozen at start
    always_comb begin
        n_valid_d = n_valid_q;
        skip_n_d  = skip_n_q;
        if (state_q == ST_IDLE && start) begin
            skip_n_d = keep_n & n_valid_q;
        end
        if (state_q == ST_FETCH_N && lsu.lsu_done && cnt_q == CW'(WORDS - 1)) begin
            n_valid_d = 1'b1;
        end
    end

    // N cache registers
    always_ff @(posedge clk) begin
        if (rst) begin
            n_valid_q <= 1'b0;
            skip_n_q  <= 1'b0;
        end else begin
            n_valid_q <= n_valid_d;
            skip_n_q  <= skip_n_d;
        end
    end

    assign skip_n = skip_n_q;
`else
    logic unused_keep_n;
    assign unused_keep_n = keep_n;
    assign skip_n        = 1'b0;
`endif

    // next-state, datapath and next-output computation
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        b_d     = b_q;
        n_d     = n_q;
        a_sh_d  = a_sh_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        op_d    = op_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d     = '0;
                    op_d    = op;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = ST_FETCH_B;
                end
            end
            ST_FETCH_B: begin
                if (lsu.lsu_done) begin
                    b_d[{cnt_q, 5'd0} +: 32] = lsu.lsu_rdata;
                    if (cnt_q == CW'(WORDS - 1)) begin
                        cnt_d   = '0;
                        state_d = skip_n ? ST_FETCH_A : ST_FETCH_N;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_FETCH_N: begin
                if (lsu.lsu_done) begin
                    n_d[{cnt_q, 5'd0} +: 32] = lsu.lsu_rdata;
                    if (cnt_q == CW'(WORDS - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_FETCH_A;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_FETCH_A: begin
                // squaring reuses B as the A operand, no LSU traffic
                if (op_q == MM_OP_SQR) begin
                    a_sh_d  = b_q[{bit_q[BW-1:5], 5'd0} +: 32];
                    state_d = ST_RUN;
                end else if (lsu.lsu_done) begin
                    a_sh_d  = lsu.lsu_rdata;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                m_d    = chain[RADIX_BITS];
                a_sh_d = a_sh_q >> RADIX_BITS;
                bit_d  = bit_q + BW'(RADIX_BITS);
                if (bit_d == BW'(BITS)) begin
                    state_d = ST_CLEANUP;
                end else if (bit_d[4:0] == 5'd0) begin
                    state_d = ST_FETCH_A;
                end
            end
            ST_CLEANUP: begin
                // M < 2N here, so one conditional subtract fully reduces it
                if (m_q >= {2'b00, n_q}) begin
                    m_d = m_q - {2'b00, n_q};
                end
                cnt_d   = '0;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (lsu.lsu_done) begin
                    if (cnt_q == CW'(WORDS - 1)) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // outputs follow the next state so they are registered and glitch-free
        ren_d   = (state_d == ST_FETCH_B) || (state_d == ST_FETCH_N) ||
                  ((state_d == ST_FETCH_A) && (op_d == MM_OP_MUL));
        wen_d   = (state_d == ST_WRITE);
        sel_d   = SEL_B;
        off_d   = '0;
        wdata_d = '0;
        case (state_d)
            ST_FETCH_B: begin
                sel_d = SEL_B;
                off_d = {{(30 - CW){1'b0}}, cnt_d, 2'b00};
            end
            ST_FETCH_N: begin
                sel_d = SEL_N;
                off_d = {{(30 - CW){1'b0}}, cnt_d, 2'b00};
            end
            ST_FETCH_A: begin
                if (op_d == MM_OP_MUL) begin
                    sel_d = SEL_A;
                    off_d = {{(29 - CW){1'b0}}, bit_d[BW-1:5], 2'b00};
                end
            end
            ST_WRITE: begin
                sel_d   = SEL_RES;
                off_d   = {{(30 - CW){1'b0}}, cnt_d, 2'b00};
                wdata_d = m_d[{cnt_d, 5'd0} +: 32];
            end
            default: ;
        endcase
    end

    // state, datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            b_q     <= '0;
            n_q     <= '0;
            a_sh_q  <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            op_q    <= 1'b0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            sel_q   <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            b_q     <= b_d;
            n_q     <= n_d;
            a_sh_q  <= a_sh_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            op_q    <= op_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            sel_q   <= sel_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

    assign lsu.lsu_ren         = ren_q;
    assign lsu.lsu_wen         = wen_q;
    assign lsu.lsu_type        = `DATA_WORD;
    assign lsu.lsu_addr_offset = off_q;
    assign lsu.op_address_sel  = sel_q;
    assign lsu.lsu_wdata       = wdata_q;
    assign result              = m_q[BITS-1:0];
    assign busy                = (state_q != ST_IDLE);
    assign done                = done_q;
endmodule

// File: tb/tb_mont_mul_rk.sv
// Bench for mont_mul_rk: three instances (RADIX_BITS 2, 1, 8) with an LSU responder model.
// Latency: checked against the zero-wait formula; random wait states later.
// Backpressure: responder inserts 0..max_wait idle cycles before each lsu_done.
`timescale 1ns/1ps
`ifndef DATA_WORD
`define DATA_WORD 2'd2
`endif
module tb_mont_mul_rk;
    localparam int W    = 4;
    localparam int BITS = 32 * W;
    localparam int NI   = 3;

    function automatic int rb_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 8);
    endfunction

    function automatic int lat_of(input int rb);
        return 1 + 2 * W + W * (1 + 32 / rb) + 1 + W;
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            start   [NI];
    logic            op      [NI];
    logic            keep_n  [NI];
    wire [BITS-1:0]  result  [NI];
    wire             busy    [NI];
    wire             done    [NI];
    wire             ren     [NI];
    wire             wen     [NI];
    wire [1:0]       ltype   [NI];
    wire [1:0]       sel     [NI];
    wire [31:0]      off     [NI];
    wire [31:0]      wdata   [NI];
    logic            ldone   [NI];
    logic [31:0]     rdata   [NI];

    logic [31:0] opmem  [NI][3][W];
    logic [31:0] resmem [NI][W];
    int rd_cnt [NI];
    int wr_cnt [NI];
    int s1_cnt [NI];
    int s2_cnt [NI];
    int both_cnt [NI];
    int wcnt [NI];
    int max_wait = 0;

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mont_mul_rk_if u_if ();
        mont_mul_rk #(.WORDS(W), .RADIX_BITS(rb_of(g))) u_dut (
            .clk    (clk),
            .rst    (rst),
            .start  (start[g]),
            .op     (op[g]),
            .keep_n (keep_n[g]),
            .lsu    (u_if),
            .result (result[g]),
            .busy   (busy[g]),
            .done   (done[g])
        );
        assign ren[g]         = u_if.lsu_ren;
        assign wen[g]         = u_if.lsu_wen;
        assign ltype[g]       = u_if.lsu_type;
        assign sel[g]         = u_if.op_address_sel;
        assign off[g]         = u_if.lsu_addr_offset;
        assign wdata[g]       = u_if.lsu_wdata;
        assign u_if.lsu_done  = ldone[g];
        assign u_if.lsu_rdata = rdata[g];
    end

    // LSU responder: answers on the falling edge so the DUT sees lsu_done at the next rising edge
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (ren[i] && wen[i]) both_cnt[i]++;
            if (sel[i] == 2'd2) s2_cnt[i]++;
            if (rst || !(ren[i] || wen[i])) begin
                ldone[i] = 1'b0;
            end else if (wcnt[i] > 0) begin
                wcnt[i]--;
                ldone[i] = 1'b0;
            end else begin
                ldone[i] = 1'b1;
                wcnt[i]  = $urandom_range(0, max_wait);
                if (ren[i]) begin
                    rd_cnt[i]++;
                    if (sel[i] == 2'd1) s1_cnt[i]++;
                    rdata[i] = (sel[i] < 2'd3) ? opmem[i][sel[i]][off[i][3:2]] : 32'hDEAD_BEEF;
                end else begin
                    wr_cnt[i]++;
                    resmem[i][off[i][3:2]] = wdata[i];
                end
            end
        end
    end

    // reference: reduce A*B mod N, then divide by two BITS times in the residue ring
    function automatic logic [BITS-1:0] ref_mont(input logic [BITS-1:0] a, b, n);
        logic [2*BITS+1:0] x;
        logic [2*BITS+1:0] nn;
        nn = {{(BITS+2){1'b0}}, n};
        x  = ({{(BITS+2){1'b0}}, a} * {{(BITS+2){1'b0}}, b}) % nn;
        for (int k = 0; k < BITS; k++) x = x[0] ? ((x + nn) >> 1) : (x >> 1);
        return x[BITS-1:0];
    endfunction

    function automatic logic [BITS-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic load(input int i, input logic [BITS-1:0] a, b, n);
        for (int w = 0; w < W; w++) begin
            opmem[i][0][w] = b[32*w +: 32];
            opmem[i][1][w] = n[32*w +: 32];
            opmem[i][2][w] = a[32*w +: 32];
        end
    endtask

    task automatic do_op(input int i, input string tag, input logic opv, input logic keepv,
                         input logic [BITS-1:0] a, b, n, input int exp_lat,
                         output int d_rd, output int d_wr, output int d_s1, output int d_s2,
                         output logic [BITS-1:0] res);
        int r0, w0, s10, s20, b0, cyc;
        logic ok;
        logic [BITS-1:0] exp, wb;
        load(i, a, b, n);
        r0 = rd_cnt[i]; w0 = wr_cnt[i]; s10 = s1_cnt[i]; s20 = s2_cnt[i]; b0 = both_cnt[i];
        exp = (opv == 1'b1) ? ref_mont(b, b, n) : ref_mont(a, b, n);
        @(negedge clk);
        start[i] = 1'b1; op[i] = opv; keep_n[i] = keepv;
        cyc = 0; ok = 1'b0;
        while (!ok && cyc < 20000) begin
            @(posedge clk); #1;
            start[i] = 1'b0;
            cyc++;
            if (done[i]) ok = 1'b1;
        end
        check({tag, "_done_seen"}, ok, 1);
        check({tag, "_result"}, result[i], exp);
        check({tag, "_busy_at_done"}, busy[i], 0);
        if (exp_lat > 0) check({tag, "_latency"}, cyc, exp_lat);
        res = result[i];
        @(posedge clk); #1;
        check({tag, "_done_one_cycle"}, done[i], 0);
        wb = {resmem[i][3], resmem[i][2], resmem[i][1], resmem[i][0]};
        check({tag, "_written_back"}, wb, exp);
        check({tag, "_no_rw_overlap"}, both_cnt[i] - b0, 0);
        d_rd = rd_cnt[i] - r0; d_wr = wr_cnt[i] - w0;
        d_s1 = s1_cnt[i] - s10; d_s2 = s2_cnt[i] - s20;
    endtask

    initial begin
        logic [BITS-1:0] nall, a, b, n, r, r1;
        int drd, dwr, ds1, ds2, n_exp;
        nall = '1;
        for (int i = 0; i < NI; i++) begin
            start[i] = 1'b0; op[i] = 1'b0; keep_n[i] = 1'b0;
        end

        // reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy[0], 0);
        check("rst_done", done[0], 0);
        check("rst_result", result[0], 0);
        check("rst_ren_wen", {ren[0], wen[0]}, 0);
        check("rst_sel_off", {sel[0], off[0]}, 0);
        check("rst_wdata", wdata[0], 0);
        check("rst_type", ltype[0], `DATA_WORD);
        @(negedge clk); rst = 1'b0;

        // small MUL, N = 2^128-1
        a = 128'd3; b = 128'd5;
        do_op(0, "mul3x5", 1'b0, 1'b0, a, b, nall, lat_of(2), drd, dwr, ds1, ds2, r);
        check("mul3x5_const", r, 128'd15);
        check("mul3x5_reads", drd, 12);
        check("mul3x5_writes", dwr, 4);

        // 2^64 * 2^64: cleanup boundary
        a = 128'd1 << 64; b = a;
        do_op(0, "mul2p64", 1'b0, 1'b0, a, b, nall, lat_of(2), drd, dwr, ds1, ds2, r);
        check("mul2p64_const", r, 128'd1);

        // squaring
        a = '0; b = 128'd7;
        do_op(0, "sqr7", 1'b1, 1'b0, a, b, nall, 0, drd, dwr, ds1, ds2, r);
        check("sqr7_const", r, 128'd49);
        check("sqr7_reads", drd, 8);
        check("sqr7_no_sel_a", ds2, 0);

        // N reuse
`ifdef MONT_MUL_N_CACHE_EN
        n_exp = 0;
`else
        n_exp = W;
`endif
        n = rnd128() | 128'd1 | (128'd1 << 127);
        a = rnd128(); b = rnd128() % n;
        do_op(0, "keep_first", 1'b0, 1'b0, a, b, n, 0, drd, dwr, ds1, ds2, r);
        check("keep_first_n_reads", ds1, W);
        do_op(0, "keep_second", 1'b0, 1'b1, a, b, n, 0, drd, dwr, ds1, ds2, r1);
        check("keep_second_n_reads", ds1, n_exp);
        check("keep_same_result", r1, r);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        do_op(0, "keep_after_rst", 1'b0, 1'b1, a, b, n, 0, drd, dwr, ds1, ds2, r);
        check("keep_after_rst_n_reads", ds1, W);

        // other radices, zero-wait latency
        for (int i = 1; i < NI; i++) begin
            n = rnd128() | 128'd1;
            a = rnd128(); b = rnd128() % n;
            do_op(i, $sformatf("rb%0d_lat", rb_of(i)), 1'b0, 1'b0, a, b, n, lat_of(rb_of(i)),
                  drd, dwr, ds1, ds2, r);
        end

        // reset in the middle of RUN
        load(0, rnd128(), rnd128() >> 1, nall);
        @(negedge clk); start[0] = 1'b1; op[0] = 1'b0; keep_n[0] = 1'b0;
        @(posedge clk); #1; start[0] = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check("midrun_busy_before", busy[0], 1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("midrun_busy", busy[0], 0);
        check("midrun_result", result[0], 0);
        check("midrun_lsu", {ren[0], wen[0], sel[0], off[0], wdata[0], done[0]}, 0);
        check("midrun_type", ltype[0], `DATA_WORD);
        @(negedge clk); rst = 1'b0;
        a = rnd128(); n = rnd128() | 128'd1; b = rnd128() % n;
        do_op(0, "after_midrun", 1'b0, 1'b0, a, b, n, lat_of(2), drd, dwr, ds1, ds2, r);

        // random operands with random LSU wait states
        max_wait = 5;
        for (int i = 0; i < NI; i++) begin
            for (int t = 0; t < 4; t++) begin
                n = rnd128() | 128'd1;
                if (t == 0) n = n | (128'd1 << 127);
                a = rnd128(); b = rnd128() % n;
                do_op(i, $sformatf("rand_i%0d_t%0d", i, t), (t == 3) ? 1'b1 : 1'b0,
                      t[0], a, b, n, 0, drd, dwr, ds1, ds2, r);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
